dac_sample_scheduler: RTL and testbench



---
 rtl/dac_sample_scheduler.sv | 143 ++++++++++++++
 tb/tb_dac_sample_scheduler.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/dac_sample_scheduler.sv
// Paced sample source for the LTC1667 write interface: buffers samples in a FIFO and
// issues one single-cycle start per sample-period tick, tracking underruns and missed ticks.
module dac_sample_scheduler #(
  parameter int DEPTH    = 16,
  parameter int PERIOD_W = 16,
  parameter int CNT_W    = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [PERIOD_W-1:0]          period,
  input  logic                         s_valid,
  input  logic [13:0]                  s_data,
  output logic                         s_ready,
  input  logic                         dac_busy,
  output logic                         dac_start,
  output logic [13:0]                  dac_data,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
  output logic                         underrun,
  output logic [CNT_W-1:0]             underrun_count,
  output logic [CNT_W-1:0]             missed_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic [13:0]         mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic                pending_q, pending_d;
  logic                dac_start_q, dac_start_d;
  logic [13:0]         dac_data_q, dac_data_d;
  logic                underrun_q, underrun_d;
  logic [CNT_W-1:0]    underrun_count_q, underrun_count_d;
  logic [CNT_W-1:0]    missed_count_q, missed_count_d;

  logic                push, pop, empty, full, tick, tick_ne, can_issue;
  logic [PERIOD_W-1:0] p_m1;

  always_comb begin
    full      = (level_q == LVL_W'(DEPTH));
    empty     = (level_q == '0);
    push      = s_valid && !full;
    // A period of 0 behaves as 1; >= keeps the counter from wrapping when period shrinks.
    p_m1      = (period == '0) ? '0 : period - PERIOD_W'(1);
    tick      = enable && (cnt_q >= p_m1);
    tick_ne   = tick && !empty;
    can_issue = !dac_busy && !dac_start_q;
    pop       = enable && (pending_q || tick_ne) && can_issue && !empty;
  end

  always_comb begin
    cnt_d            = cnt_q;
    pending_d        = pending_q;
    dac_start_d      = 1'b0;
    dac_data_d       = dac_data_q;
    underrun_d       = 1'b0;
    underrun_count_d = underrun_count_q;
    missed_count_d   = missed_count_q;
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    level_d          = level_q;

    if (!enable) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + PERIOD_W'(1);
    end

    if (tick && empty) begin
      underrun_d = 1'b1;
      if (underrun_count_q != '1) underrun_count_d = underrun_count_q + CNT_W'(1);
    end
    if (tick_ne && pending_q) begin
      if (missed_count_q != '1) missed_count_d = missed_count_q + CNT_W'(1);
    end

    if (!enable) begin
      pending_d = 1'b0;
    end else if (pop) begin
      pending_d = 1'b0;
    end else if (tick_ne) begin
      pending_d = 1'b1;
    end

    if (pop) begin
      dac_start_d = 1'b1;
      dac_data_d  = mem_q[rd_ptr_q];
      rd_ptr_d    = rd_ptr_q + PTR_W'(1);
    end
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      level_q          <= '0;
      cnt_q            <= '0;
      pending_q        <= 1'b0;
      dac_start_q      <= 1'b0;
      dac_data_q       <= '0;
      underrun_q       <= 1'b0;
      underrun_count_q <= '0;
      missed_count_q   <= '0;
    end else begin
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      level_q          <= level_d;
      cnt_q            <= cnt_d;
      pending_q        <= pending_d;
      dac_start_q      <= dac_start_d;
      dac_data_q       <= dac_data_d;
      underrun_q       <= underrun_d;
      underrun_count_q <= underrun_count_d;
      missed_count_q   <= missed_count_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (!reset && push) mem_q[wr_ptr_q] <= s_data;
  end

  assign s_ready        = !full;
  assign dac_start      = dac_start_q;
  assign dac_data       = dac_data_q;
  assign fifo_level     = level_q;
  assign underrun       = underrun_q;
  assign underrun_count = underrun_count_q;
  assign missed_count   = missed_count_q;

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// Directed bench for dac_sample_scheduler: inputs change and outputs are sampled 1 ns after posedge.
module tb_dac_sample_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] period = 16'd0;
  logic        s_valid = 1'b0;
  logic [13:0] s_data = 14'd0;
  logic        s_ready;
  logic        dac_busy = 1'b0;
  logic        dac_start;
  logic [13:0] dac_data;
  logic [4:0]  fifo_level;
  logic        underrun;
  logic [15:0] underrun_count;
  logic [15:0] missed_count;

  int vectors = 0;
  int miscompares = 0;
  bit bm_en = 1'b0;
  int bcnt = 0;

  always #5 clk = ~clk;

  dac_sample_scheduler #(.DEPTH(16), .PERIOD_W(16), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .period(period),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .dac_busy(dac_busy), .dac_start(dac_start), .dac_data(dac_data),
    .fifo_level(fifo_level), .underrun(underrun),
    .underrun_count(underrun_count), .missed_count(missed_count)
  );

  // One clock; the optional busy model holds dac_busy for 12 cycles after each start.
  task automatic step();
    @(posedge clk);
    #1;
    if (bm_en) begin
      if (dac_start) bcnt = 12;
      else if (bcnt != 0) bcnt = bcnt - 1;
      dac_busy = (bcnt != 0);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; s_valid = 1'b0; dac_busy = 1'b0; bm_en = 1'b0; bcnt = 0;
    step();
    reset = 1'b0;
  endtask

  task automatic push_word(input logic [13:0] d);
    s_valid = 1'b1; s_data = d;
    step();
    s_valid = 1'b0;
  endtask

  task automatic test_reset();
    s_valid = 1'b1; s_data = 14'h1555;
    do_reset();
    s_valid = 1'b0;
    vectors++; if (dac_start !== 1'b0) begin miscompares++; $display("FAIL rst_start got %b exp 0", dac_start); end
    vectors++; if (dac_data !== 14'h0) begin miscompares++; $display("FAIL rst_data got %h exp 0", dac_data); end
    vectors++; if (underrun !== 1'b0) begin miscompares++; $display("FAIL rst_underrun got %b exp 0", underrun); end
    vectors++; if (underrun_count !== 16'd0) begin miscompares++; $display("FAIL rst_ucnt got %0d exp 0", underrun_count); end
    vectors++; if (missed_count !== 16'd0) begin miscompares++; $display("FAIL rst_mcnt got %0d exp 0", missed_count); end
    vectors++; if (fifo_level !== 5'd0) begin miscompares++; $display("FAIL rst_level got %0d exp 0", fifo_level); end
    vectors++; if (s_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready got %b exp 1", s_ready); end
  endtask

  task automatic test_stream();
    logic [13:0] exp_d [3];
    int n;
    exp_d[0] = 14'h0001; exp_d[1] = 14'h1FFF; exp_d[2] = 14'h3FFF;
    do_reset();
    period = 16'd20;
    for (int k = 0; k < 3; k++) push_word(exp_d[k]);
    vectors++; if (fifo_level !== 5'd3) begin miscompares++; $display("FAIL stream_level got %0d exp 3", fifo_level); end
    bm_en = 1'b1; enable = 1'b1; n = 0;
    for (int i = 1; i <= 65; i++) begin
      step();
      if (dac_start) begin
        vectors++; if (i != 20 * (n + 1)) begin miscompares++; $display("FAIL stream_time got %0d exp %0d", i, 20 * (n + 1)); end
        if (n < 3) begin
          vectors++; if (dac_data !== exp_d[n]) begin miscompares++; $display("FAIL stream_data got %h exp %h", dac_data, exp_d[n]); end
        end
        n++;
      end
    end
    vectors++; if (n != 3) begin miscompares++; $display("FAIL stream_starts got %0d exp 3", n); end
    vectors++; if (dac_data !== 14'h3FFF) begin miscompares++; $display("FAIL stream_hold got %h exp 3fff", dac_data); end
    vectors++; if (underrun_count !== 16'd0) begin miscompares++; $display("FAIL stream_ucnt got %0d exp 0", underrun_count); end
    vectors++; if (missed_count !== 16'd0) begin miscompares++; $display("FAIL stream_mcnt got %0d exp 0", missed_count); end
    enable = 1'b0; bm_en = 1'b0; dac_busy = 1'b0;
  endtask

  task automatic test_underrun();
    int nu, ns, first;
    do_reset();
    period = 16'd8; enable = 1'b1; nu = 0; ns = 0; first = 0;
    for (int i = 1; i <= 24; i++) begin
      step();
      if (underrun) begin nu++; if (first == 0) first = i; end
      if (dac_start) ns++;
    end
    enable = 1'b0;
    vectors++; if (nu != 3) begin miscompares++; $display("FAIL und_pulses got %0d exp 3", nu); end
    vectors++; if (first != 8) begin miscompares++; $display("FAIL und_first got %0d exp 8", first); end
    vectors++; if (ns != 0) begin miscompares++; $display("FAIL und_starts got %0d exp 0", ns); end
    vectors++; if (underrun_count !== 16'd3) begin miscompares++; $display("FAIL und_count got %0d exp 3", underrun_count); end
  endtask

  task automatic test_period_zero();
    do_reset();
    period = 16'd0; enable = 1'b1;
    for (int i = 0; i < 3; i++) step();
    vectors++; if (underrun_count !== 16'd3) begin miscompares++; $display("FAIL p0_ucnt got %0d exp 3", underrun_count); end
    s_valid = 1'b1; s_data = 14'h1234;
    step();
    s_valid = 1'b0;
    vectors++; if (underrun !== 1'b1) begin miscompares++; $display("FAIL p0_push_und got %b exp 1", underrun); end
    vectors++; if (underrun_count !== 16'd4) begin miscompares++; $display("FAIL p0_ucnt4 got %0d exp 4", underrun_count); end
    step();
    vectors++; if (dac_start !== 1'b1) begin miscompares++; $display("FAIL p0_start got %b exp 1", dac_start); end
    vectors++; if (dac_data !== 14'h1234) begin miscompares++; $display("FAIL p0_data got %h exp 1234", dac_data); end
    vectors++; if (fifo_level !== 5'd0) begin miscompares++; $display("FAIL p0_level got %0d exp 0", fifo_level); end
    enable = 1'b0;
  endtask

  task automatic test_busy_deferral();
    int early;
    do_reset();
    period = 16'd8;
    push_word(14'h0ABC);
    dac_busy = 1'b1; enable = 1'b1; early = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (dac_start) early++;
    end
    vectors++; if (early != 0) begin miscompares++; $display("FAIL defer_early got %0d exp 0", early); end
    dac_busy = 1'b0;
    step();
    vectors++; if (dac_start !== 1'b1) begin miscompares++; $display("FAIL defer_start got %b exp 1", dac_start); end
    vectors++; if (dac_data !== 14'h0ABC) begin miscompares++; $display("FAIL defer_data got %h exp 0abc", dac_data); end
    enable = 1'b0;
    step();
    vectors++; if (dac_start !== 1'b0) begin miscompares++; $display("FAIL defer_fall got %b exp 0", dac_start); end
  endtask

  task automatic test_missed_tick();
    int early;
    do_reset();
    period = 16'd4;
    for (int k = 0; k < 6; k++) push_word(14'h0100 + 14'(k));
    dac_busy = 1'b1; enable = 1'b1; early = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (dac_start) early++;
    end
    vectors++; if (early != 0) begin miscompares++; $display("FAIL miss_early got %0d exp 0", early); end
    dac_busy = 1'b0;
    step();
    enable = 1'b0;
    vectors++; if (dac_start !== 1'b1) begin miscompares++; $display("FAIL miss_start got %b exp 1", dac_start); end
    vectors++; if (dac_data !== 14'h0100) begin miscompares++; $display("FAIL miss_data got %h exp 0100", dac_data); end
    vectors++; if (missed_count !== 16'd4) begin miscompares++; $display("FAIL miss_count got %0d exp 4", missed_count); end
    vectors++; if (fifo_level !== 5'd5) begin miscompares++; $display("FAIL miss_level got %0d exp 5", fifo_level); end
  endtask

  // Continues from test_missed_tick state (level 5, dac_data 0x0100, missed 4).
  task automatic test_reset_midrun();
    push_word(14'h0200);
    push_word(14'h0201);
    vectors++; if (fifo_level !== 5'd7) begin miscompares++; $display("FAIL mid_level7 got %0d exp 7", fifo_level); end
    dac_busy = 1'b1; period = 16'd2; enable = 1'b1;
    for (int i = 0; i < 3; i++) step();
    reset = 1'b1; s_valid = 1'b1; s_data = 14'h0333;
    step();
    reset = 1'b0; s_valid = 1'b0; enable = 1'b0; dac_busy = 1'b0;
    vectors++; if (fifo_level !== 5'd0) begin miscompares++; $display("FAIL mid_level got %0d exp 0", fifo_level); end
    vectors++; if (dac_start !== 1'b0) begin miscompares++; $display("FAIL mid_start got %b exp 0", dac_start); end
    vectors++; if (dac_data !== 14'h0) begin miscompares++; $display("FAIL mid_data got %h exp 0", dac_data); end
    vectors++; if (missed_count !== 16'd0) begin miscompares++; $display("FAIL mid_mcnt got %0d exp 0", missed_count); end
    vectors++; if (underrun_count !== 16'd0) begin miscompares++; $display("FAIL mid_ucnt got %0d exp 0", underrun_count); end
    vectors++; if (s_ready !== 1'b1) begin miscompares++; $display("FAIL mid_ready got %b exp 1", s_ready); end
  endtask

  task automatic test_backpressure();
    int n;
    bit first_seen;
    do_reset();
    for (int i = 1; i <= 20; i++) begin
      s_valid = 1'b1; s_data = 14'(i);
      vectors++; if (s_ready !== (i <= 16)) begin miscompares++; $display("FAIL bp_ready_%0d got %b exp %b", i, s_ready, (i <= 16)); end
      step();
    end
    s_valid = 1'b0;
    vectors++; if (fifo_level !== 5'd16) begin miscompares++; $display("FAIL bp_level got %0d exp 16", fifo_level); end
    period = 16'd1; enable = 1'b1; n = 0; first_seen = 1'b0;
    for (int i = 0; i < 40 && n < 16; i++) begin
      step();
      if (dac_start) begin
        vectors++; if (dac_data !== 14'(n + 1)) begin miscompares++; $display("FAIL bp_order got %h exp %h", dac_data, 14'(n + 1)); end
        if (!first_seen) begin
          first_seen = 1'b1;
          vectors++; if (s_ready !== 1'b1) begin miscompares++; $display("FAIL bp_ready_pop got %b exp 1", s_ready); end
        end
        n++;
      end
    end
    enable = 1'b0;
    vectors++; if (n != 16) begin miscompares++; $display("FAIL bp_drained got %0d exp 16", n); end
    vectors++; if (fifo_level !== 5'd0) begin miscompares++; $display("FAIL bp_level_end got %0d exp 0", fifo_level); end
  endtask

  initial begin
    step();
    step();
    test_reset();
    test_stream();
    test_underrun();
    test_period_zero();
    test_busy_deferral();
    test_missed_tick();
    test_reset_midrun();
    test_backpressure();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
